// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 encodings, FSM state type and alignment helper for the LSU
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } lsu_state_e;

    // Unlisted funct3 codes are treated as word accesses.
    function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            SB, LBU: return 1'b1;
            SH, LHU: return ~addr_lo[0];
            default: return (addr_lo == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// rtl/lsu_data_align.sv - byte-lane steering: byte enables, store replication, load extraction
module lsu_data_align
    import lsu_pkg::*;
(
    input  logic [2:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] load_word_i,
    output logic [3:0]  byte_en_o,
    output logic [31:0] store_data_o,
    output logic [31:0] load_data_o
);

    logic [31:0] shifted;

    assign shifted = load_word_i >> {addr_lo_i, 3'b000};

    always_comb begin
        byte_en_o    = 4'b1111;
        store_data_o = store_data_i;
        case (size_i)
            SB, LBU: begin
                byte_en_o    = 4'b0001 << addr_lo_i;
                store_data_o = {4{store_data_i[7:0]}};
            end
            SH, LHU: begin
                byte_en_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
                store_data_o = {2{store_data_i[15:0]}};
            end
            SW: begin
                byte_en_o    = 4'b1111;
                store_data_o = store_data_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        load_data_o = load_word_i;
        case (size_i)
            LB:      load_data_o = {{24{shifted[7]}}, shifted[7:0]};
            LH:      load_data_o = {{16{shifted[15]}}, shifted[15:0]};
            LBU:     load_data_o = {24'h0, shifted[7:0]};
            LHU:     load_data_o = {16'h0, shifted[15:0]};
            LW:      load_data_o = load_word_i;
            default: load_data_o = load_word_i;
        endcase
    end

endmodule

// File: rtl/lsu_riscv.sv
// rtl/lsu_riscv.sv - RISC-V load/store unit: request/handshake FSM with misalignment and watchdog faults
module lsu_riscv
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_stall_o,
    output logic        lsu_misaligned_o,
    output logic        lsu_fault_o,
    output logic        data_require,
    output logic        data_write_enable,
    output logic [3:0]  data_byte_enable_map,
    output logic [31:0] data_address,
    output logic [31:0] data_write,
    input  logic [31:0] data_read,
    input  logic        data_begin,
    input  logic        data_end
);

    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        size_q, size_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       load_q, load_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              mis_q, mis_d;
    logic              fault_q, fault_d;

    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata;
    logic [31:0]       lane_rdata;
    logic              timeout;
    logic              in_req;

    lsu_data_align u_align (
        .size_i       (size_q),
        .addr_lo_i    (addr_q[1:0]),
        .store_data_i (wdata_q),
        .load_word_i  (data_read),
        .byte_en_o    (lane_be),
        .store_data_o (lane_wdata),
        .load_data_o  (lane_rdata)
    );

    // Fires in the last allowed REQ/WAIT cycle so DONE lands TIMEOUT_CYCLES after REQ entry.
    assign timeout = (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            load_q  <= 32'h0;
            wdog_q  <= '0;
            mis_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            load_q  <= load_d;
            wdog_q  <= wdog_d;
            mis_q   <= mis_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        load_d  = load_q;
        wdog_d  = wdog_q;
        mis_d   = mis_q;
        fault_d = fault_q;
        case (state_q)
            S_IDLE: begin
                if (lsu_req_i) begin
                    mis_d   = 1'b0;
                    fault_d = 1'b0;
                    if (is_aligned(lsu_size_i, lsu_addr_i[1:0])) begin
                        we_d    = lsu_we_i;
                        size_d  = lsu_size_i;
                        addr_d  = lsu_addr_i;
                        wdata_d = lsu_data_i;
                        wdog_d  = '0;
                        state_d = S_REQ;
                    end else begin
                        mis_d   = 1'b1;
                        load_d  = 32'h0;
                        state_d = S_DONE;
                    end
                end
            end
            S_REQ: begin
                wdog_d = wdog_q + 1'b1;
                if (data_begin) begin
                    load_d = lane_rdata;
                end
                if (data_begin && data_end) begin
                    state_d = S_DONE;
                end else if (timeout) begin
                    fault_d = 1'b1;
                    load_d  = 32'h0;
                    state_d = S_DONE;
                end else if (data_begin) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                wdog_d = wdog_q + 1'b1;
                if (data_end) begin
                    state_d = S_DONE;
                end else if (timeout) begin
                    fault_d = 1'b1;
                    load_d  = 32'h0;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are gated with reset so the memory side goes quiet in the reset cycle itself.
    assign in_req               = reset && (state_q == S_REQ);
    assign data_require         = in_req;
    assign data_write_enable    = in_req && we_q;
    assign data_byte_enable_map = in_req ? lane_be : 4'b0000;
    assign data_address         = in_req ? addr_q : 32'h0;
    assign data_write           = in_req ? lane_wdata : 32'h0;

    assign lsu_data_o       = reset ? load_q : 32'h0;
    assign lsu_misaligned_o = reset && (state_q == S_DONE) && mis_q;
    assign lsu_fault_o      = reset && (state_q == S_DONE) && fault_q;
    assign lsu_stall_o      = lsu_req_i && (state_q != S_DONE);

endmodule

// File: tb/tb_lsu_riscv.sv
// tb/tb_lsu_riscv.sv - scoreboard testbench for lsu_riscv with a delay-programmable memory model
module tb_lsu_riscv;
    import lsu_pkg::*;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        lsu_req_i = 1'b0;
    logic        lsu_we_i = 1'b0;
    logic [2:0]  lsu_size_i = 3'b000;
    logic [31:0] lsu_addr_i = 32'h0;
    logic [31:0] lsu_data_i = 32'h0;
    logic [31:0] lsu_data_o;
    logic        lsu_stall_o;
    logic        lsu_misaligned_o;
    logic        lsu_fault_o;
    logic        data_require;
    logic        data_write_enable;
    logic [3:0]  data_byte_enable_map;
    logic [31:0] data_address;
    logic [31:0] data_write;
    logic [31:0] data_read = 32'h0;
    logic        data_begin = 1'b0;
    logic        data_end = 1'b0;

    always #5 clk = ~clk;

    lsu_riscv #(.TIMEOUT_CYCLES(TO)) dut (
        .clk                  (clk),
        .reset                (reset),
        .lsu_req_i            (lsu_req_i),
        .lsu_we_i             (lsu_we_i),
        .lsu_size_i           (lsu_size_i),
        .lsu_addr_i           (lsu_addr_i),
        .lsu_data_i           (lsu_data_i),
        .lsu_data_o           (lsu_data_o),
        .lsu_stall_o          (lsu_stall_o),
        .lsu_misaligned_o     (lsu_misaligned_o),
        .lsu_fault_o          (lsu_fault_o),
        .data_require         (data_require),
        .data_write_enable    (data_write_enable),
        .data_byte_enable_map (data_byte_enable_map),
        .data_address         (data_address),
        .data_write           (data_write),
        .data_read            (data_read),
        .data_begin           (data_begin),
        .data_end             (data_end)
    );

    typedef struct {
        logic [31:0] data;
        logic        chk_data;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] addr;
        logic        we;
        logic        mis;
        logic        fault;
        int          lat;
        int          rq;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail = 0;

    function automatic logic ref_aligned(input logic [2:0] f, input logic [1:0] a);
        if (f == 3'b000 || f == 3'b100) return 1'b1;
        if (f == 3'b001 || f == 3'b101) return (a == 2'b00 || a == 2'b10);
        return (a == 2'b00);
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f, input logic [1:0] a);
        if (f == 3'b000 || f == 3'b100) begin
            case (a)
                2'd0: return 4'b0001;
                2'd1: return 4'b0010;
                2'd2: return 4'b0100;
                default: return 4'b1000;
            endcase
        end
        if (f == 3'b001 || f == 3'b101) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f, input logic [31:0] d);
        if (f == 3'b000 || f == 3'b100) return {d[7:0], d[7:0], d[7:0], d[7:0]};
        if (f == 3'b001 || f == 3'b101) return {d[15:0], d[15:0]};
        return d;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [31:0] w, input logic [1:0] a);
        logic [7:0] b [4];
        logic [7:0] lo;
        logic [7:0] hi;
        for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
        lo = a[1] ? b[2] : b[0];
        hi = a[1] ? b[3] : b[1];
        case (f)
            3'b000: return {{24{b[a][7]}}, b[a]};
            3'b100: return {24'h000000, b[a]};
            3'b001: return {{16{hi[7]}}, hi, lo};
            3'b101: return {16'h0000, hi, lo};
            default: return w;
        endcase
    endfunction

    task automatic run_txn(input logic we, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] mw, input int bd, input int ed);
        exp_t e;
        int n, rq, wcnt, c;
        logic fin, began, owe, omis, oflt;
        logic [3:0] obe;
        logic [31:0] owd, oad, odat;
        c = bd + ed;
        e.mis      = !ref_aligned(f, a[1:0]);
        e.fault    = !e.mis && (c >= TO);
        e.chk_data = !we;
        e.data     = (e.mis || e.fault) ? 32'h0 : ref_load(f, mw, a[1:0]);
        e.be       = ref_be(f, a[1:0]);
        e.wdata    = ref_wdata(f, d);
        e.addr     = a;
        e.we       = we;
        e.lat      = e.mis ? 1 : (e.fault ? TO + 1 : c + 2);
        e.rq       = e.mis ? 0 : (e.fault ? ((bd + 1 < TO) ? bd + 1 : TO) : bd + 1);
        sb.push_back(e);

        @(negedge clk);
        lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = f; lsu_addr_i = a; lsu_data_i = d;
        data_read = mw; data_begin = 1'b0; data_end = 1'b0;
        n = 0; rq = 0; wcnt = 0; fin = 1'b0; began = 1'b0;
        obe = 4'h0; owd = 32'h0; oad = 32'h0; owe = 1'b0; omis = 1'b0; oflt = 1'b0; odat = 32'h0;
        while (!fin && n < 200) begin
            @(negedge clk);
            n++;
            if (data_require) begin
                rq++;
                if (rq == 1) begin
                    obe = data_byte_enable_map; owd = data_write; oad = data_address; owe = data_write_enable;
                end
            end
            if (!lsu_stall_o) begin
                fin = 1'b1; omis = lsu_misaligned_o; oflt = lsu_fault_o; odat = lsu_data_o;
            end
            data_begin = 1'b0; data_end = 1'b0;
            if (!fin) begin
                if (data_require) begin
                    if (rq > bd) begin
                        data_begin = 1'b1; began = 1'b1;
                        if (ed == 0) data_end = 1'b1;
                    end
                end else if (began) begin
                    wcnt++;
                    if (wcnt >= ed) data_end = 1'b1;
                end
            end
        end
        lsu_req_i = 1'b0;

        e = sb.pop_front();
        n_checks++; if (fin !== 1'b1) begin n_fail++; $display("FAIL done_reached: got %0b expected 1", fin); end
        n_checks++; if (n != e.lat) begin n_fail++; $display("FAIL latency a=%h f=%0d: got %0d expected %0d", a, f, n, e.lat); end
        n_checks++; if (rq != e.rq) begin n_fail++; $display("FAIL req_cycles a=%h: got %0d expected %0d", a, rq, e.rq); end
        n_checks++; if (omis !== e.mis) begin n_fail++; $display("FAIL misaligned a=%h: got %0b expected %0b", a, omis, e.mis); end
        n_checks++; if (oflt !== e.fault) begin n_fail++; $display("FAIL fault a=%h: got %0b expected %0b", a, oflt, e.fault); end
        if (e.chk_data) begin
            n_checks++; if (odat !== e.data) begin n_fail++; $display("FAIL load_data a=%h f=%0d: got %h expected %h", a, f, odat, e.data); end
        end
        if (e.rq > 0) begin
            n_checks++; if (obe !== e.be) begin n_fail++; $display("FAIL byte_enable a=%h: got %b expected %b", a, obe, e.be); end
            n_checks++; if (owd !== e.wdata) begin n_fail++; $display("FAIL write_data a=%h: got %h expected %h", a, owd, e.wdata); end
            n_checks++; if (oad !== e.addr) begin n_fail++; $display("FAIL address: got %h expected %h", oad, e.addr); end
            n_checks++; if (owe !== e.we) begin n_fail++; $display("FAIL write_enable a=%h: got %0b expected %0b", a, owe, e.we); end
        end

        @(negedge clk);
        n_checks++; if (data_require !== 1'b0) begin n_fail++; $display("FAIL idle_require: got %0b expected 0", data_require); end
        if (e.chk_data) begin
            n_checks++; if (lsu_data_o !== e.data) begin n_fail++; $display("FAIL load_hold a=%h: got %h expected %h", a, lsu_data_o, e.data); end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; lsu_req_i = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (data_require !== 1'b0) begin n_fail++; $display("FAIL rst_require: got %0b expected 0", data_require); end
        n_checks++; if ({data_write_enable, data_byte_enable_map, data_address, data_write} !== 69'h0) begin
            n_fail++; $display("FAIL rst_mem_outputs: got %h expected 0", {data_write_enable, data_byte_enable_map, data_address, data_write}); end
        n_checks++; if (lsu_data_o !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h expected 0", lsu_data_o); end
        n_checks++; if ({lsu_misaligned_o, lsu_fault_o} !== 2'b00) begin n_fail++; $display("FAIL rst_pulses: got %b expected 00", {lsu_misaligned_o, lsu_fault_o}); end
        n_checks++; if (lsu_stall_o !== 1'b1) begin n_fail++; $display("FAIL rst_stall: got %0b expected 1", lsu_stall_o); end
        lsu_req_i = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (lsu_stall_o !== 1'b0) begin n_fail++; $display("FAIL idle_stall: got %0b expected 0", lsu_stall_o); end
    endtask

    task automatic test_store_word();
        run_txn(1'b1, SW, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1);
    endtask

    task automatic test_load_byte();
        run_txn(1'b0, LB, 32'h13, 32'h0, 32'h80FF0102, 0, 0);
        run_txn(1'b0, LBU, 32'h13, 32'h0, 32'h80FF0102, 1, 2);
        run_txn(1'b0, LH, 32'h12, 32'h0, 32'h80FF0102, 0, 1);
        run_txn(1'b0, LHU, 32'h12, 32'h0, 32'h80FF0102, 0, 1);
    endtask

    task automatic test_store_half();
        run_txn(1'b1, SH, 32'h22, 32'h0000ABCD, 32'h0, 0, 1);
        run_txn(1'b1, SB, 32'h31, 32'h000000A5, 32'h0, 0, 0);
    endtask

    task automatic test_misaligned();
        run_txn(1'b0, LW, 32'h06, 32'h0, 32'h11223344, 0, 0);
        run_txn(1'b1, SH, 32'h41, 32'h1234, 32'h0, 0, 0);
    endtask

    task automatic test_timeout();
        run_txn(1'b0, LW, 32'h80, 32'h0, 32'h55AA55AA, 1000, 0);
    endtask

    task automatic test_ignore_idle();
        logic [31:0] held;
        held = lsu_data_o;
        @(negedge clk);
        data_read = 32'hCAFEF00D; data_begin = 1'b1; data_end = 1'b1;
        repeat (2) begin
            @(negedge clk);
            n_checks++; if (data_require !== 1'b0) begin n_fail++; $display("FAIL idle_ignore_req: got %0b expected 0", data_require); end
            n_checks++; if (lsu_data_o !== held) begin n_fail++; $display("FAIL idle_ignore_data: got %h expected %h", lsu_data_o, held); end
        end
        data_begin = 1'b0; data_end = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = LW; lsu_addr_i = 32'h40; data_read = 32'h12345678;
        @(negedge clk);
        n_checks++; if (data_require !== 1'b1) begin n_fail++; $display("FAIL mid_req: got %0b expected 1", data_require); end
        data_begin = 1'b1;
        @(negedge clk);
        data_begin = 1'b0;
        n_checks++; if (lsu_data_o !== 32'h12345678) begin n_fail++; $display("FAIL mid_capture: got %h expected 12345678", lsu_data_o); end
        reset = 1'b0; lsu_req_i = 1'b0;
        #1;
        n_checks++; if (lsu_data_o !== 32'h0) begin n_fail++; $display("FAIL mid_rst_data: got %h expected 0", lsu_data_o); end
        @(negedge clk);
        n_checks++; if ({data_require, data_write_enable, data_byte_enable_map, data_address, data_write} !== 70'h0) begin
            n_fail++; $display("FAIL mid_rst_mem: got %h expected 0", {data_require, data_byte_enable_map, data_address}); end
        reset = 1'b1;
        data_end = 1'b1;
        @(negedge clk);
        data_end = 1'b0;
        n_checks++; if (lsu_data_o !== 32'h0) begin n_fail++; $display("FAIL mid_rst_cleared: got %h expected 0", lsu_data_o); end
        n_checks++; if (data_require !== 1'b0) begin n_fail++; $display("FAIL mid_rst_idle: got %0b expected 0", data_require); end
        run_txn(1'b0, LW, 32'h44, 32'h0, 32'h0BADF00D, 0, 1);
    endtask

    task automatic test_back_to_back();
        logic [2:0] codes [5];
        logic [2:0] f;
        logic [31:0] a;
        logic we;
        codes[0] = 3'b000; codes[1] = 3'b001; codes[2] = 3'b010; codes[3] = 3'b100; codes[4] = 3'b101;
        for (int i = 0; i < 14; i++) begin
            f  = codes[$urandom_range(0, 4)];
            we = (f[2] == 1'b0) ? 1'($urandom_range(0, 1)) : 1'b0;
            a  = $urandom & 32'hFFFF_FFFC;
            if (f[1:0] == 2'b00) a[1:0] = 2'($urandom_range(0, 3));
            else if (f[1:0] == 2'b01) a[1] = 1'($urandom_range(0, 1));
            run_txn(we, f, a, $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_timeout();
        test_ignore_idle();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_riscv.md
LSU_RISCV -- requirements
Module: lsu_riscv

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: cycles allowed in REQ plus WAIT before a fault is raised.
REQ-002 SHALL have port clk, input, 1 bit: clock, all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have port lsu_req_i, input, 1 bit: core requests a load or store.
REQ-005 SHALL have port lsu_we_i, input, 1 bit: 1 = store, 0 = load.
REQ-006 SHALL have port lsu_size_i, input, 3 bits: funct3 (000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU).
REQ-007 SHALL have port lsu_addr_i, input, 32 bits: byte address.
REQ-008 SHALL have port lsu_data_i, input, 32 bits: store data, right-aligned.
REQ-009 SHALL have port lsu_data_o, output, 32 bits: load result, extended.
REQ-010 SHALL have port lsu_stall_o, output, 1 bit: core hold.
REQ-011 SHALL have port lsu_misaligned_o, output, 1 bit: misaligned-access pulse.
REQ-012 SHALL have port lsu_fault_o, output, 1 bit: timeout pulse.
REQ-013 SHALL have memory-side outputs data_require (1 bit), data_write_enable (1 bit), data_byte_enable_map (4 bits), data_address (32 bits) and data_write (32 bits).
REQ-014 SHALL have memory-side inputs data_read (32 bits), data_begin (1 bit) and data_end (1 bit).

Function
REQ-015 SHALL implement FSM states IDLE, REQ, WAIT, DONE.
REQ-016 IDLE with lsu_req_i=1 and an aligned access SHALL latch we, size, addr and data, then go to REQ.
REQ-017 Alignment rule: halfword requires addr[0]=0; word requires addr[1:0]=00; byte is always aligned.
REQ-018 IDLE with lsu_req_i=1 and a misaligned access SHALL go to DONE with lsu_misaligned_o=1 for the DONE cycle, lsu_data_o=0 and no memory access.
REQ-019 data_require SHALL be 1 only in REQ; data_write_enable, data_byte_enable_map, data_address and data_write SHALL be driven from latched values in REQ.
REQ-020 In REQ, data_begin=1 SHALL capture data_read into the load register and move to WAIT, so data_require drops on the next cycle.
REQ-021 In WAIT, data_end=1 SHALL move to DONE.
REQ-022 DONE SHALL last exactly one cycle, then return to IDLE.
REQ-023 lsu_stall_o SHALL equal lsu_req_i AND (state != DONE).
REQ-024 Minimum latency, request to DONE, SHALL be 3 cycles; the normal latency is set by the memory's data_end.
REQ-025 data_address SHALL be the latched byte address, unmodified.
REQ-026 Byte enables: byte 0001<<addr[1:0]; half 0011<<(2*addr[1]); word 1111.
REQ-027 Store data placement: byte replicated {4{d[7:0]}}; half {2{d[15:0]}}; word d unchanged.
REQ-028 Load data: select the lane shifted by 8*addr[1:0]; LB/LH sign-extend; LBU/LHU zero-extend; LW passes through; an unlisted funct3 behaves as LW.
REQ-029 lsu_data_o SHALL be the formatted load register, stable from DONE until the next capture.
REQ-030 data_begin or data_end arriving in IDLE or DONE SHALL be ignored.
REQ-031 data_begin and data_end both high in REQ SHALL capture the data and go directly to DONE.
REQ-032 A watchdog counter SHALL clear on entry to REQ and increment in REQ and WAIT.
REQ-033 When the watchdog reaches TIMEOUT_CYCLES, the FSM SHALL go to DONE with lsu_fault_o=1 for one cycle and lsu_data_o=0.
REQ-034 lsu_req_i dropping mid-transaction SHALL NOT abort it; the transaction completes and its result is discarded by the core.

Reset
REQ-035 When reset=0 at a clock edge, the FSM SHALL go to IDLE and the load register and watchdog SHALL clear.
REQ-036 In reset, all memory-side outputs, lsu_data_o, lsu_misaligned_o and lsu_fault_o SHALL be 0, and lsu_stall_o SHALL follow REQ-023.
REQ-037 Reset asserted mid-transaction SHALL abort it, with data_require=0 from the next cycle.

Structure
REQ-038 Package lsu_pkg SHALL hold the funct3 constants LB, LH, LW, LBU, LHU, SB, SH, SW and the state enum type.
REQ-039 Combinational lane logic (byte enables, store replication, load extraction and extension) SHALL live in sub-module lsu_data_align.

Verification
REQ-040 SW addr 0x10, data 0xDEADBEEF -> data_require for the REQ cycle, BE=1111, data_write=0xDEADBEEF, stall released at DONE.
REQ-041 LB addr 0x13 with memory word 0x80FF0102 -> lsu_data_o=0xFFFFFF80; LBU on the same word -> 0x00000080.
REQ-042 SH addr 0x22, data 0x0000ABCD -> BE=1100, data_write=0xABCDABCD.
REQ-043 LW addr 0x06 -> lsu_misaligned_o=1 in the cycle after the request, data_require never asserted, lsu_data_o=0.
REQ-044 Memory never asserts data_begin with TIMEOUT_CYCLES=8 -> lsu_fault_o pulses 8 cycles after REQ entry, FSM returns to IDLE.
REQ-045 reset=0 in WAIT -> next cycle state IDLE, all outputs 0; a new request is then served normally.
